// File: rtl/mine_field_gen.sv
// Minefield generator: places NUM_MINES mines from a free-running LFSR, avoiding
// the safe tile, then computes the 4-bit adjacent-mine count for every tile.
module mine_field_gen #(
    parameter int          GRID_SIZE = 8,
    parameter int          NUM_MINES = 10,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [5:0]   safe_index,
    output logic [63:0]  mine_map,
    output logic [255:0] adj,
    output logic         ready,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE,
        PLACE,
        COUNT,
        DONE
    } state_t;

    localparam logic [15:0] SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam logic [5:0]  LAST_MINE = 6'(NUM_MINES - 1);
    localparam logic [5:0]  LAST_TILE = 6'(GRID_SIZE * GRID_SIZE - 1);

    state_t         state_q, state_d;
    logic [15:0]    lfsr_q;
    logic [15:0]    lfsr_next;
    logic [5:0]     safe_q;
    logic [5:0]     cnt_q;
    logic [5:0]     t_q;
    logic [63:0]    mine_map_q;
    logic [255:0]   adj_q;
    logic [5:0]     cand;
    logic           accept;
    logic [2:0]     tx, ty;
    logic [3:0]     nsum;
    int             nx, ny;

    // Galois form of x^16+x^14+x^13+x^11+1; a nonzero state never maps to zero
    assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);

    assign cand   = lfsr_q[5:0];
    assign accept = (state_q == PLACE) && (cand != safe_q) && !mine_map_q[cand];
    assign tx     = t_q[2:0];
    assign ty     = t_q[5:3];

    // Neighbour sum for the tile under count; off-board neighbours are skipped, no wrap
    always_comb begin
        nsum = '0;
        nx   = 0;
        ny   = 0;
        for (int unsigned i = 0; i < 9; i++) begin
            if (i != 4) begin
                nx = int'(tx) + int'(i % 3) - 1;
                ny = int'(ty) + int'(i / 3) - 1;
                if (nx >= 0 && nx < GRID_SIZE && ny >= 0 && ny < GRID_SIZE) begin
                    nsum = nsum + 4'(mine_map_q[6'(ny * GRID_SIZE + nx)]);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = PLACE;
                end
            end
            PLACE: begin
                if (accept && cnt_q == LAST_MINE) begin
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (t_q == LAST_TILE) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            lfsr_q     <= SEED_EFF;
            safe_q     <= '0;
            cnt_q      <= '0;
            t_q        <= '0;
            mine_map_q <= '0;
            adj_q      <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_next;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        safe_q     <= safe_index;
                        cnt_q      <= '0;
                        t_q        <= '0;
                        mine_map_q <= '0;
                        adj_q      <= '0;
                    end
                end
                PLACE: begin
                    if (accept) begin
                        mine_map_q[cand] <= 1'b1;
                        cnt_q            <= cnt_q + 6'd1;
                    end
                end
                COUNT: begin
                    adj_q[{t_q, 2'b00} +: 4] <= nsum;
                    t_q                      <= t_q + 6'd1;
                end
                default: ;
            endcase
        end
    end

    assign mine_map = mine_map_q;
    assign adj      = adj_q;
    assign ready    = (state_q == DONE);
    assign busy     = (state_q == PLACE) || (state_q == COUNT);

endmodule

// File: tb/tb_mine_field_gen.sv
// Self-checking bench for mine_field_gen: randomized start timing and safe tiles,
// checked against a field/adjacency model derived from the LFSR rule.
module tb_mine_field_gen;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
    logic [5:0]   safe0 = '0, safe1 = '0, safe2 = '0;
    logic [63:0]  mm0, mm1, mm2;
    logic [255:0] adj0, adj1, adj2;
    logic         rd0, rd1, rd2, bz0, bz1, bz2;

    int           sel = 0;
    logic [63:0]  sel_mm;
    logic [255:0] sel_adj;
    logic         sel_rd, sel_bz;
    logic [15:0]  m_lfsr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mine_field_gen #(.NUM_MINES(10), .LFSR_SEED(16'hACE1)) dut10 (
        .clk(clk), .rst(rst), .start(start0), .safe_index(safe0),
        .mine_map(mm0), .adj(adj0), .ready(rd0), .busy(bz0));
    mine_field_gen #(.NUM_MINES(63), .LFSR_SEED(16'hACE1)) dut63 (
        .clk(clk), .rst(rst), .start(start1), .safe_index(safe1),
        .mine_map(mm1), .adj(adj1), .ready(rd1), .busy(bz1));
    mine_field_gen #(.NUM_MINES(1), .LFSR_SEED(16'hACE1)) dut1 (
        .clk(clk), .rst(rst), .start(start2), .safe_index(safe2),
        .mine_map(mm2), .adj(adj2), .ready(rd2), .busy(bz2));

    assign sel_mm  = (sel == 0) ? mm0  : (sel == 1) ? mm1  : mm2;
    assign sel_adj = (sel == 0) ? adj0 : (sel == 1) ? adj1 : adj2;
    assign sel_rd  = (sel == 0) ? rd0  : (sel == 1) ? rd1  : rd2;
    assign sel_bz  = (sel == 0) ? bz0  : (sel == 1) ? bz1  : bz2;

    function automatic logic [15:0] step(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    endfunction

    // Every DUT shares the seed and reset, so one reference LFSR serves all three
    always @(posedge clk) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= step(m_lfsr);
    end

    // Field = first n distinct non-safe low-6-bit values of the LFSR stream after start
    task automatic predict(input logic [15:0] l0, input logic [5:0] safe, input int n,
                           output logic [63:0] m, output int p);
        logic [15:0] l;
        logic [5:0]  idx;
        int          cnt;
        l = l0; m = '0; cnt = 0; p = 0;
        while (cnt < n && p < 60000) begin
            l = step(l);
            p++;
            idx = l[5:0];
            if (idx != safe && !m[idx]) begin
                m[idx] = 1'b1;
                cnt++;
            end
        end
    endtask

    function automatic logic [255:0] adj_model(input logic [63:0] m);
        logic [255:0] r;
        int c;
        r = '0;
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 8; x++) begin
                c = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        if ((dx != 0 || dy != 0) && x + dx >= 0 && x + dx < 8 &&
                            y + dy >= 0 && y + dy < 8 && m[6'((y + dy) * 8 + x + dx)])
                            c++;
                    end
                end
                r[(y * 8 + x) * 4 +: 4] = 4'(c);
            end
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input int d, input logic v, input logic [5:0] s);
        case (d)
            0:       begin start0 = v; safe0 = s; end
            1:       begin start1 = v; safe1 = s; end
            default: begin start2 = v; safe2 = s; end
        endcase
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_mm"}, sel_mm, '0);
        check({tag, "_adj"}, sel_adj, '0);
        check({tag, "_ready"}, sel_rd, 0);
        check({tag, "_busy"}, sel_bz, 0);
    endtask

    // Called at a negedge; returns at a negedge. abort asserts rst 20 cycles into COUNT.
    task automatic do_run(input int d, input int n, input logic [5:0] safe,
                          input bit pulses, input bit abort);
        logic [63:0]  emm;
        logic [255:0] eadj;
        logic [255:0] ad;
        int           p;
        int           mx;
        sel = d;
        predict(m_lfsr, safe, n, emm, p);
        eadj = adj_model(emm);
        set_start(d, 1'b1, safe);
        for (int k = 1; k <= p + 65; k++) begin
            @(negedge clk);
            if (k == 1) set_start(d, 1'b0, safe ^ 6'h15);
            if (pulses && (k == 3 || k == p + 10)) set_start(d, 1'b1, safe ^ 6'h2A);
            if (pulses && (k == 4 || k == p + 11)) set_start(d, 1'b0, safe ^ 6'h15);
            if (abort && k == p + 20) begin
                rst = 1'b1;
                @(negedge clk);
                check_zero("abort");
                rst = 1'b0;
                set_start(d, 1'b0, safe);
                return;
            end
            if (k < p + 65) begin
                check("busy_run", sel_bz, 1);
                check("ready_low", sel_rd, 0);
            end
        end
        check("ready_done", sel_rd, 1);
        check("busy_done", sel_bz, 0);
        check("mine_map", sel_mm, emm);
        check("adj", sel_adj, eadj);
        check("popcount", $countones(sel_mm), n);
        check("safe_clear", sel_mm[safe], 0);
        ad = sel_adj;
        mx = 0;
        for (int i = 0; i < 64; i++) if (int'(ad[i * 4 +: 4]) > mx) mx = int'(ad[i * 4 +: 4]);
        check("adj_le8", (mx <= 8), 1);
    endtask

    initial begin
        logic [255:0] ad;
        logic [15:0]  nxt;
        logic [5:0]   rs;
        bit           found;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_zero("idle");
        end

        // Random idle gap so start timing draws a different LFSR window
        repeat ($urandom_range(1, 40)) @(negedge clk);
        do_run(0, 10, 6'd27, 1'b0, 1'b0);
        repeat ($urandom_range(1, 40)) @(negedge clk);
        do_run(0, 10, 6'd27, 1'b1, 1'b0);
        repeat ($urandom_range(1, 40)) @(negedge clk);
        rs = 6'($urandom_range(0, 63));
        do_run(0, 10, rs, 1'b1, 1'b0);

        do_run(1, 63, 6'd0, 1'b0, 1'b0);
        ad = adj1;
        check("full_mm", mm1, 64'hFFFF_FFFF_FFFF_FFFE);
        check("full_adj0", ad[0 +: 4], 4'd3);
        check("full_adj1", ad[4 +: 4], 4'd4);
        check("full_adj27", ad[108 +: 4], 4'd8);
        check("full_adj63", ad[252 +: 4], 4'd3);
        check("full_adj7", ad[28 +: 4], 4'd3);

        // Wait for a start slot whose first candidate is tile 7
        found = 1'b0;
        for (int w = 0; w < 5000 && !found; w++) begin
            nxt = step(m_lfsr);
            if (nxt[5:0] == 6'd7) found = 1'b1;
            else @(negedge clk);
        end
        check("edge_slot", found, 1);
        do_run(2, 1, 6'd0, 1'b0, 1'b0);
        ad = adj2;
        check("edge_mm", mm2, 64'h0000_0000_0000_0080);
        check("edge_adj8", ad[32 +: 4], 4'd0);
        check("edge_adj6", ad[24 +: 4], 4'd1);
        check("edge_adj14", ad[56 +: 4], 4'd1);
        check("edge_adj15", ad[60 +: 4], 4'd1);
        check("edge_adj0", ad[0 +: 4], 4'd0);

        repeat ($urandom_range(1, 40)) @(negedge clk);
        rs = 6'($urandom_range(0, 63));
        do_run(0, 10, rs, 1'b0, 1'b1);
        rs = 6'($urandom_range(0, 63));
        do_run(0, 10, rs, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mine_field_gen.md
Name: mine_field_gen

Overview:
Generates the hidden minefield that the per-pixel renderer and the tile state logic consume. It places NUM_MINES mines pseudo-randomly on the GRID_SIZE x GRID_SIZE board using a free-running LFSR, never placing one on the player's chosen safe tile. It then computes the 4-bit adjacent-mine count for every tile and presents both the mine bitmap and the packed adjacency vector, with a ready flag. It sits directly upstream of the renderer and drives its mine_map and adj inputs.

Parameters:
GRID_SIZE, 8, tiles per row/column; the board is GRID_SIZE*GRID_SIZE = 64 tiles; only 8 is supported.
NUM_MINES, 10, mines placed per game; legal range 1..63.
LFSR_SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'h0001.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
start  input  1  single-cycle request to generate a new field; ignored while busy
safe_index  input  6  tile guaranteed mine-free (y*8+x), sampled on an accepted start
mine_map  output  64  bit i = 1 if tile i holds a mine
adj  output  256  adj[i*4 +: 4] = mines among the 8 neighbours of tile i (0..8)
ready  output  1  high while mine_map and adj are valid and stable
busy  output  1  high during PLACE and COUNT

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high. On reset: state=IDLE, mine_map=0, adj=0, ready=0, busy=0, lfsr=LFSR_SEED (or 1 if the seed is 0), placed count=0.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. It steps every cycle after reset, including in IDLE and DONE, so the user's timing of start gives the entropy. It never reaches 0.
- States: IDLE, PLACE, COUNT, DONE.
- IDLE or DONE with start=1:
  - Latch safe_index.
  - Clear mine_map, adj and the placed count.
  - ready <= 0, busy <= 1, go to PLACE.
- start while in PLACE or COUNT: ignored, no effect.
- PLACE, each cycle:
  - Candidate cand = lfsr[5:0].
  - If cand != safe_index and mine_map[cand] == 0: set mine_map[cand] and increment the placed count.
  - Otherwise the cycle is rejected and nothing changes.
  - When the count reaches NUM_MINES (checked on the registered count), go to COUNT with tile index t=0.
  - Minimum PLACE duration is NUM_MINES cycles; rejected cycles extend it.
- COUNT, one tile per cycle, t = 0..63:
  - tx = t[2:0], ty = t[5:3].
  - Sum mine_map over the 8 neighbours, excluding any neighbour with tx±1 or ty±1 outside 0..7. There is no wrap-around: tile 7 does not see tile 8.
  - Write the sum to adj[t*4 +: 4]. Mine tiles also receive their neighbour count.
  - After t=63 is written, go to DONE. COUNT takes exactly 64 cycles.
- DONE: ready=1, busy=0. mine_map and adj hold until the next accepted start or reset.
- Output timing:
  - ready rises on the cycle after adj[63] is written.
  - Total latency from an accepted start to ready is (1 + PLACE cycles + 64) cycles.
- Stability: while ready=0, mine_map and adj are undefined for consumers. Downstream logic must gate reveals on ready.
- Reset mid-operation (PLACE or COUNT): abort immediately to the reset values. A partial field is never exposed with ready=1.
- Invariants in DONE:
  - popcount(mine_map) == NUM_MINES.
  - mine_map[safe_index] == 0.
  - Every adj nibble is ≤ 8.

Test Plan:
- Reset then idle 20 cycles -> mine_map=0, adj=0, ready=0, busy=0; the LFSR sequence from 16'hACE1 matches the reference model cycle by cycle.
- NUM_MINES=10, start with safe_index=27 -> ready within 1+10+64 cycles plus the rejected cycles; popcount(mine_map)=10; mine_map[27]=0; adj matches the software neighbour count for all 64 tiles.
- NUM_MINES=63, safe_index=0 -> mine_map=64'hFFFF_FFFF_FFFF_FFFE; adj[0]=3, adj[1]=4, adj[27]=8, adj[63]=3, adj[7]=3.
- Edge/no-wrap check: force a field with only tile 7 mined -> adj[8]=0, adj[6]=1, adj[14]=1, adj[15]=1, adj[0]=0.
- start pulses at cycle 3 of PLACE and cycle 10 of COUNT -> ignored; safe_index stays the original; the result is identical to a run without them.
- rst asserted mid-COUNT, then a fresh start -> outputs are 0 and ready=0 the cycle after rst; the new run completes normally with all invariants holding.
